// File: rtl/prop_mon_pkg.sv
// Shared types and helpers for the prop_monitor bounded-response checker.
package prop_mon_pkg;

  // Per-channel checker state: IDLE has no open obligation, WAIT has one.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ch_state_e;

  // Width of a delay counter able to hold 0..max_dly.
  function automatic int dly_width(input int max_dly);
    return $clog2(max_dly + 1);
  endfunction

  // Add two counts and clamp the result to the largest value of a w-bit counter.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w);
    logic [63:0] limit;
    logic [63:0] sum;
    limit = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sum   = a + b;
    if (sum > limit) begin
      return limit;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/prop_mon_ch.sv
// One checker channel for ante |-> ##[MIN_DLY:MAX_DLY] cons.
// pass/fail are same-cycle strobes for the completing posedge; the top
// registers them. busy is registered and high exactly while in WAIT.
module prop_mon_ch
  import prop_mon_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ante,
  input  logic cons,
  output logic busy,
  output logic pass,
  output logic fail
);

  localparam int DLY_W = dly_width(MAX_DLY);
  localparam logic [DLY_W:0] MIN_V = (DLY_W + 1)'(MIN_DLY);
  localparam logic [DLY_W:0] MAX_V = (DLY_W + 1)'(MAX_DLY);

  ch_state_e        state_r;
  logic [DLY_W-1:0] cnt_r;
  logic             busy_r;
  logic [DLY_W:0]   elapsed_s;
  logic             pass_s;
  logic             fail_s;

  // Evaluate the open obligation: cycles since trigger, pass and fail strobes.
  always_comb begin
    elapsed_s = {1'b0, cnt_r} + (DLY_W + 1)'(1);
    pass_s    = 1'b0;
    fail_s    = 1'b0;
    if (en && (state_r == WAIT)) begin
      if (cons && (elapsed_s >= MIN_V)) begin
        pass_s = 1'b1;
      end else if (elapsed_s == MAX_V) begin
        fail_s = 1'b1;
      end else begin
        pass_s = 1'b0;
      end
    end else begin
      fail_s = 1'b0;
    end
  end

  // Channel FSM; en=0 silently drops any open obligation.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ante) begin
            state_r <= WAIT;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        WAIT: begin
          if (pass_s || fail_s) begin
            // a trigger on the completing edge opens a fresh obligation
            state_r <= ante ? WAIT : IDLE;
            cnt_r   <= '0;
            busy_r  <= ante;
          end else begin
            cnt_r   <= cnt_r + DLY_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign pass = pass_s;
  assign fail = fail_s;

endmodule

// File: rtl/prop_monitor.sv
// NUM_CH independent bounded-response checkers with failure pulse, sticky
// flags and a saturating failure count. Optional coverage outputs
// (pass_pulse, pass_cnt) are built when PROP_MON_COVER_EN is defined.
module prop_monitor
  import prop_mon_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] ante,
  input  logic [NUM_CH-1:0] cons,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] err_pulse,
  output logic [NUM_CH-1:0] err_sticky,
  output logic [CNT_W-1:0]  err_cnt
`ifdef PROP_MON_COVER_EN
  ,
  output logic [NUM_CH-1:0] pass_pulse,
  output logic [CNT_W-1:0]  pass_cnt
`endif
);

  localparam int POP_W = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] pass_s;
  logic [NUM_CH-1:0] fail_s;
  logic [POP_W-1:0]  fail_pop_s;
  logic [NUM_CH-1:0] err_pulse_r;
  logic [NUM_CH-1:0] err_sticky_r;
  logic [CNT_W-1:0]  err_cnt_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    prop_mon_ch #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .ante (ante[i]),
      .cons (cons[i]),
      .busy (busy[i]),
      .pass (pass_s[i]),
      .fail (fail_s[i])
    );
  end

  // Number of channels failing at this edge.
  always_comb begin
    fail_pop_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fail_pop_s = fail_pop_s + POP_W'(fail_s[i]);
    end
  end

  // Failure reporting; clr restarts sticky/count from this edge's failures.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse_r  <= '0;
      err_sticky_r <= '0;
      err_cnt_r    <= '0;
    end else begin
      err_pulse_r <= fail_s;
      if (clr) begin
        err_sticky_r <= fail_s;
        err_cnt_r    <= CNT_W'(fail_pop_s);
      end else begin
        err_sticky_r <= err_sticky_r | fail_s;
        err_cnt_r    <= CNT_W'(sat_add(64'(err_cnt_r), 64'(fail_pop_s), CNT_W));
      end
    end
  end

  assign err_pulse  = err_pulse_r;
  assign err_sticky = err_sticky_r;
  assign err_cnt    = err_cnt_r;

`ifdef PROP_MON_COVER_EN
  logic [POP_W-1:0]  pass_pop_s;
  logic [NUM_CH-1:0] pass_pulse_r;
  logic [CNT_W-1:0]  pass_cnt_r;

  // Number of channels passing at this edge.
  always_comb begin
    pass_pop_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_pop_s = pass_pop_s + POP_W'(pass_s[i]);
    end
  end

  // Pass coverage strobe and saturating pass count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_pulse_r <= '0;
      pass_cnt_r   <= '0;
    end else begin
      pass_pulse_r <= pass_s;
      if (clr) begin
        pass_cnt_r <= CNT_W'(pass_pop_s);
      end else begin
        pass_cnt_r <= CNT_W'(sat_add(64'(pass_cnt_r), 64'(pass_pop_s), CNT_W));
      end
    end
  end

  assign pass_pulse = pass_pulse_r;
  assign pass_cnt   = pass_cnt_r;
`else
  // Pass strobes only feed the optional coverage logic.
  logic unused_pass_s;
  assign unused_pass_s = ^pass_s;
`endif

endmodule

// File: tb/tb_prop_monitor.sv
// Self-checking bench for prop_monitor (NUM_CH=2, MIN_DLY=1, MAX_DLY=3, CNT_W=4).
// Reference model tracks, per channel, the cycle number of the open trigger.
module tb_prop_monitor;

  localparam int NUM_CH  = 2;
  localparam int MIN_DLY = 1;
  localparam int MAX_DLY = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst, en, clr;
  logic [NUM_CH-1:0] ante, cons;
  logic [NUM_CH-1:0] busy, err_pulse, err_sticky;
  logic [CNT_W-1:0]  err_cnt;
`ifdef PROP_MON_COVER_EN
  logic [NUM_CH-1:0] pass_pulse;
  logic [CNT_W-1:0]  pass_cnt;
`endif

  always #5 clk = ~clk;

  prop_monitor #(
    .NUM_CH  (NUM_CH),
    .MIN_DLY (MIN_DLY),
    .MAX_DLY (MAX_DLY),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .ante       (ante),
    .cons       (cons),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
`ifdef PROP_MON_COVER_EN
    ,
    .pass_pulse (pass_pulse),
    .pass_cnt   (pass_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  int                start_m [NUM_CH];
  logic [NUM_CH-1:0] busy_m, pulse_m, sticky_m;
  int                cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Apply the property rules for one edge using the inputs currently driven.
  task automatic model_edge();
    logic [NUM_CH-1:0] f;
    int nf, d;
    bit done;
    cyc++;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) start_m[i] = -1;
      pulse_m = '0; sticky_m = '0; cnt_m = 0;
    end else begin
      f = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en) begin
          start_m[i] = -1;
        end else if (start_m[i] >= 0) begin
          d = cyc - start_m[i];
          done = 0;
          if (cons[i] && d >= MIN_DLY) done = 1;
          else if (d >= MAX_DLY) begin done = 1; f[i] = 1'b1; end
          if (done) start_m[i] = ante[i] ? cyc : -1;
        end else if (ante[i]) begin
          start_m[i] = cyc;
        end
      end
      nf = 0;
      for (int i = 0; i < NUM_CH; i++) nf += int'(f[i]);
      pulse_m = f;
      if (clr) begin
        sticky_m = f; cnt_m = nf;
      end else begin
        sticky_m = sticky_m | f;
        cnt_m = (cnt_m + nf > CNT_MAX) ? CNT_MAX : cnt_m + nf;
      end
    end
    for (int i = 0; i < NUM_CH; i++) busy_m[i] = (start_m[i] >= 0);
  endtask

  // Drive one cycle of inputs, advance an edge, then compare against the model.
  task automatic step(input logic r, input logic e, input logic c,
                      input logic [NUM_CH-1:0] a, input logic [NUM_CH-1:0] q);
    rst = r; en = e; clr = c; ante = a; cons = q;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy",       32'(busy),       32'(busy_m));
    chk("err_pulse",  32'(err_pulse),  32'(pulse_m));
    chk("err_sticky", 32'(err_sticky), 32'(sticky_m));
    chk("err_cnt",    32'(err_cnt),    32'(cnt_m));
  endtask

  int busy_cycles;

  initial begin
    for (int i = 0; i < NUM_CH; i++) start_m[i] = -1;
    busy_m = '0; pulse_m = '0; sticky_m = '0; cnt_m = 0;
    rst = 1'b1; en = 1'b1; clr = 1'b0; ante = '0; cons = '0;

    // reset state
    step(1'b1, 1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("rst_outputs", 32'({busy, err_pulse, err_sticky, err_cnt}), 32'd0);

    // ch0 triggered, consequent two edges later: pass, busy for 2 cycles
    busy_cycles = 0;
    step(1'b0, 1'b1, 1'b0, 2'b01, 2'b00); busy_cycles += int'(busy[0]);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00); busy_cycles += int'(busy[0]);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b01); busy_cycles += int'(busy[0]);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00); busy_cycles += int'(busy[0]);
    chk("pass_busy_cycles", 32'(busy_cycles), 32'd2);
    chk("pass_no_err", 32'(err_sticky), 32'd0);

    // ch1 never sees its consequent: fails on the third edge after trigger
    step(1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("fail_not_early", 32'(err_pulse), 32'd0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("fail_pulse", 32'(err_pulse), 32'b10);
    chk("fail_sticky", 32'(err_sticky), 32'b10);
    chk("fail_cnt", 32'(err_cnt), 32'd1);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("fail_pulse_one_cycle", 32'(err_pulse), 32'd0);

    // both channels fail together eight times: count climbs by 2 and saturates
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
      step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
      chk("dual_fail_pulse", 32'(err_pulse), 32'b11);
    end
    chk("cnt_saturated", 32'(err_cnt), 32'd15);

    // consequent on the trigger edge and after the window are both ignored
    step(1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b01, 2'b01);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("late_cons_fail", 32'(err_pulse), 32'b01);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b01);
    chk("late_cons_idle", 32'(busy), 32'd0);

    // en drop discards the obligation, then clr coincides with a failure
    step(1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    chk("en_drop_idle", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("en_drop_no_err", 32'(err_pulse), 32'd0);
    step(1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    chk("clr_fail_cnt", 32'(err_cnt), 32'd1);
    chk("clr_fail_sticky", 32'(err_sticky), 32'b01);

    // reset while both channels are busy drops everything silently
    step(1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
    chk("both_busy", 32'(busy), 32'b11);
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("rst_mid_outputs", 32'({busy, err_pulse, err_sticky, err_cnt}), 32'd0);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
    chk("rst_mid_no_err", 32'(err_sticky), 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 92),
           ($urandom_range(99) < 5), NUM_CH'($urandom), NUM_CH'($urandom_range(3) == 0 ? $urandom : 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
